// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: button conditioning plus idle/ready/play/pause/over game sequencer.
// Optional feature macro AUTO_RESTART_EN: leave OVER for READY automatically once the hold time expires.
// Latency: raw button edge to press pulse 2+DB_CYCLES clocks; FSM outputs registered one clock after the press.
module game_flow_ctrl #(
    parameter int DB_CYCLES   = 250000,
    parameter int OVER_FRAMES = 120,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             pushin,
    input  logic             began,
    input  logic             paus,
    input  logic             quit,
    input  logic [2:0]       choice,
    input  logic             collision,
    output logic [2:0]       state,
    output logic             step,
    output logic             flap,
    output logic             clear,
    output logic [2:0]       level,
    output logic [CNT_W-1:0] play_frames
);

    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HOLD_W = $clog2(OVER_FRAMES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_FRAMES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } st_t;

    st_t cur;

    // Button bits: 0=pushin 1=began 2=paus 3=quit
    logic [3:0]      btn_raw;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      deb;
    logic [3:0]      deb_q;
    logic [3:0]      press;
    logic [DB_W-1:0] db_cnt [4];
    logic [2:0]      choice_s1;
    logic [2:0]      choice_s2;
    logic [HOLD_W-1:0] hold;

    assign btn_raw = {quit, paus, began, pushin};
    assign press   = deb & ~deb_q;
    assign state   = cur;

    // Synchronize and debounce all buttons; choice only gets the synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            deb_q     <= '0;
            choice_s1 <= '0;
            choice_s2 <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            deb_q     <= deb;
            choice_s1 <= choice;
            choice_s2 <= choice_s1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Game state machine with registered pulse outputs and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= IDLE;
            step        <= 1'b0;
            flap        <= 1'b0;
            clear       <= 1'b0;
            level       <= '0;
            play_frames <= '0;
            hold        <= '0;
        end else begin
            step  <= 1'b0;
            flap  <= 1'b0;
            clear <= 1'b0;
            case (cur)
                IDLE: begin
                    if (press[1]) begin
                        cur         <= READY;
                        level       <= choice_s2;
                        clear       <= 1'b1;
                        play_frames <= '0;
                    end
                end
                READY: begin
                    if (press[3]) begin
                        cur <= IDLE;
                    end else if (press[0]) begin
                        cur  <= PLAY;
                        flap <= 1'b1;
                    end
                end
                PLAY: begin
                    if (press[3]) begin
                        cur <= IDLE;
                    end else if (collision) begin
                        // The frame of the crash is not counted as survived.
                        cur  <= OVER;
                        hold <= '0;
                    end else begin
                        if (frame_tick) begin
                            step <= 1'b1;
                            if (play_frames != {CNT_W{1'b1}})
                                play_frames <= play_frames + CNT_W'(1);
                        end
                        if (press[2])
                            cur <= PAUSE;
                        else if (press[0])
                            flap <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (press[3])
                        cur <= IDLE;
                    else if (press[2])
                        cur <= PLAY;
                end
                OVER: begin
                    if (press[3]) begin
                        cur <= IDLE;
                    end else begin
                        if (frame_tick && hold != HOLD_MAX)
                            hold <= hold + HOLD_W'(1);
`ifdef AUTO_RESTART_EN
                        if (hold == HOLD_MAX) begin
`else
                        if (hold == HOLD_MAX && press[1]) begin
`endif
                            cur         <= READY;
                            level       <= choice_s2;
                            clear       <= 1'b1;
                            play_frames <= '0;
                        end
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl with DB_CYCLES=4, OVER_FRAMES=3.
// Table of {inputs, cycles, expected outputs} plus a hand-written async reset sequence.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick, pushin, began, paus, quit, collision;
    logic [2:0]  choice;
    logic [2:0]  state;
    logic        step, flap, clear;
    logic [2:0]  level;
    logic [15:0] play_frames;

    int checks = 0;
    int errors = 0;

    game_flow_ctrl #(.DB_CYCLES(4), .OVER_FRAMES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .pushin(pushin),
        .began(began), .paus(paus), .quit(quit), .choice(choice),
        .collision(collision), .state(state), .step(step), .flap(flap),
        .clear(clear), .level(level), .play_frames(play_frames)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b, p, ps, q, ft, co;
        logic [2:0] ch;
        int         n;
        logic [2:0] st;
        logic       fl, cl, sp;
        logic [2:0] lv;
        logic [15:0] fr;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic b, p, ps, q, ft, co, input logic [2:0] ch, input int n,
                       input logic [2:0] st, input logic fl, cl, sp,
                       input logic [2:0] lv, input logic [15:0] fr);
        vec_t v;
        v.b = b; v.p = p; v.ps = ps; v.q = q; v.ft = ft; v.co = co; v.ch = ch; v.n = n;
        v.st = st; v.fl = fl; v.cl = cl; v.sp = sp; v.lv = lv; v.fr = fr;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%0d expected=%0d @%0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, p, ps, q, ft, co, input logic [2:0] ch);
        began = b; pushin = p; paus = ps; quit = q; frame_tick = ft; collision = co; choice = ch;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 3'd0);

        // start: began held, press after 6 clocks, READY one clock later
        add(1,0,0,0,0,0,5,6, 0,0,0,0,0,0);
        add(1,0,0,0,0,0,5,1, 1,0,1,0,5,0);
        add(1,0,0,0,0,0,5,3, 1,0,0,0,5,0);
        add(0,0,0,0,0,0,5,8, 1,0,0,0,5,0);
        // 2-clock pushin glitch ignored
        add(0,1,0,0,0,0,5,2, 1,0,0,0,5,0);
        add(0,0,0,0,0,0,5,8, 1,0,0,0,5,0);
        // pushin held: PLAY with flap
        add(0,1,0,0,0,0,5,6, 1,0,0,0,5,0);
        add(0,1,0,0,0,0,5,1, 2,1,0,0,5,0);
        add(0,1,0,0,0,0,5,1, 2,0,0,0,5,0);
        add(0,0,0,0,0,0,5,8, 2,0,0,0,5,0);
        // five frame ticks in PLAY
        for (int k = 1; k <= 5; k++) begin
            add(0,0,0,0,1,0,5,1, 2,0,0,1,5,16'(k));
            add(0,0,0,0,0,0,5,1, 2,0,0,0,5,16'(k));
        end
        // pause, ticks ignored, resume
        add(0,0,1,0,0,0,5,6, 2,0,0,0,5,5);
        add(0,0,1,0,0,0,5,1, 3,0,0,0,5,5);
        add(0,0,0,0,0,0,5,8, 3,0,0,0,5,5);
        for (int k = 0; k < 3; k++) begin
            add(0,0,0,0,1,0,5,1, 3,0,0,0,5,5);
            add(0,0,0,0,0,0,5,1, 3,0,0,0,5,5);
        end
        add(0,0,1,0,0,0,5,6, 3,0,0,0,5,5);
        add(0,0,1,0,0,0,5,1, 2,0,0,0,5,5);
        add(0,0,0,0,0,0,5,8, 2,0,0,0,5,5);
        // collision coinciding with a frame tick: OVER, no step
        add(0,0,0,0,1,1,5,1, 4,0,0,0,5,5);
        add(0,0,0,0,0,1,2,1, 4,0,0,0,5,5);
        add(0,0,0,0,0,0,2,1, 4,0,0,0,5,5);
        // one tick, then began is ignored
        add(0,0,0,0,1,0,2,1, 4,0,0,0,5,5);
        add(0,0,0,0,0,0,2,1, 4,0,0,0,5,5);
        add(1,0,0,0,0,0,2,7, 4,0,0,0,5,5);
        add(0,0,0,0,0,0,2,8, 4,0,0,0,5,5);
        // ticks 2 and 3
        add(0,0,0,0,1,0,2,1, 4,0,0,0,5,5);
        add(0,0,0,0,0,0,2,1, 4,0,0,0,5,5);
        add(0,0,0,0,1,0,2,1, 4,0,0,0,5,5);
`ifdef AUTO_RESTART_EN
        add(0,0,0,0,0,0,2,1, 1,0,1,0,2,0);
        add(0,0,0,0,0,0,2,8, 1,0,0,0,2,0);
`else
        add(0,0,0,0,0,0,2,1, 4,0,0,0,5,5);
        add(1,0,0,0,0,0,2,6, 4,0,0,0,5,5);
        add(1,0,0,0,0,0,2,1, 1,0,1,0,2,0);
        add(0,0,0,0,0,0,2,8, 1,0,0,0,2,0);
`endif
        // back to PLAY, flap inside PLAY, one tick
        add(0,1,0,0,0,0,2,6, 1,0,0,0,2,0);
        add(0,1,0,0,0,0,2,1, 2,1,0,0,2,0);
        add(0,0,0,0,0,0,2,8, 2,0,0,0,2,0);
        add(0,1,0,0,0,0,2,6, 2,0,0,0,2,0);
        add(0,1,0,0,0,0,2,1, 2,1,0,0,2,0);
        add(0,0,0,0,0,0,2,8, 2,0,0,0,2,0);
        add(0,0,0,0,1,0,2,1, 2,0,0,1,2,1);
        add(0,0,0,0,0,0,2,1, 2,0,0,0,2,1);
        // quit + paus press with collision: quit wins
        add(0,0,1,1,0,0,2,6, 2,0,0,0,2,1);
        add(0,0,1,1,0,1,2,1, 0,0,0,0,2,1);
        add(0,0,0,0,0,0,2,8, 0,0,0,0,2,1);

        clocks(2);
        rst = 1'b0;
        chk("reset_state", -1, 16'(state), 0);
        chk("reset_step",  -1, 16'(step), 0);
        chk("reset_flap",  -1, 16'(flap), 0);
        chk("reset_clear", -1, 16'(clear), 0);
        chk("reset_level", -1, 16'(level), 0);
        chk("reset_frames", -1, play_frames, 0);

        foreach (tv[i]) begin
            drive(tv[i].b, tv[i].p, tv[i].ps, tv[i].q, tv[i].ft, tv[i].co, tv[i].ch);
            clocks(tv[i].n);
            chk("state",  i, 16'(state), 16'(tv[i].st));
            chk("flap",   i, 16'(flap),  16'(tv[i].fl));
            chk("clear",  i, 16'(clear), 16'(tv[i].cl));
            chk("step",   i, 16'(step),  16'(tv[i].sp));
            chk("level",  i, 16'(level), 16'(tv[i].lv));
            chk("frames", i, play_frames, tv[i].fr);
        end

        // Hand sequence: reach PLAY with a frame counted, then async reset mid-cycle
        drive(1, 0, 0, 0, 0, 0, 3'd6);
        clocks(8);
        drive(0, 0, 0, 0, 0, 0, 3'd6);
        clocks(8);
        chk("seq_ready", 100, 16'(state), 1);
        chk("seq_level", 100, 16'(level), 6);
        drive(0, 1, 0, 0, 0, 0, 3'd6);
        clocks(8);
        drive(0, 0, 0, 0, 0, 0, 3'd6);
        clocks(8);
        drive(0, 0, 0, 0, 1, 0, 3'd6);
        clocks(1);
        drive(0, 0, 0, 0, 0, 0, 3'd6);
        clocks(1);
        chk("seq_play",   100, 16'(state), 2);
        chk("seq_frames", 100, play_frames, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_state",  101, 16'(state), 0);
        chk("async_level",  101, 16'(level), 0);
        chk("async_frames", 101, play_frames, 0);
        chk("async_flap",   101, 16'(flap), 0);
        clocks(2);
        rst = 1'b0;
        clocks(3);
        chk("post_reset_idle", 102, 16'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the flappy-bird datapath.
- Conditions the raw push buttons (pushin, began, paus, quit) into one-cycle press pulses.
- Runs the game state machine (idle / ready / play / pause / game-over) and drives `state[2:0]` to the top level.
- Gates per-frame world advance, issues flap and clear pulses, latches the difficulty choice and counts survived frames.

Parameters:
- DB_CYCLES, 250000: clocks an input must hold a new level before its debounced value changes. Bench uses 4.
- OVER_FRAMES, 120: frame ticks spent in OVER before a restart is accepted. Bench uses 3.
- CNT_W, 16: width of play_frames.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse per video frame (from VS logic).
- pushin  in  1  raw flap button.
- began  in  1  raw start button.
- paus  in  1  raw pause toggle button.
- quit  in  1  raw quit button.
- choice  in  3  raw difficulty switches.
- collision  in  1  level from the collision logic; high while the bird overlaps a pipe or the ground.
- state  out  3  0=IDLE 1=READY 2=PLAY 3=PAUSE 4=OVER.
- step  out  1  world-advance pulse.
- flap  out  1  one-cycle flap pulse to the bird physics.
- clear  out  1  one-cycle pulse to reset pipes, bird and score.
- level  out  3  difficulty latched at game start.
- play_frames  out  CNT_W  frames survived in the current game.

Behaviour:
- Reset (async, rst=1): state=IDLE; step, flap and clear = 0; level=0; play_frames=0; all sync, debounce and edge registers = 0; hold counter = 0.
- Input conditioning, per button:
  - 2-flop synchronizer, then a debounce counter.
  - Counter resets whenever the synced value equals the debounced value. Otherwise it increments; at DB_CYCLES-1 the debounced value takes the synced value.
  - Press pulse = debounced rising edge, high exactly 1 cycle.
  - Total latency from raw edge to press pulse = 2 + DB_CYCLES clocks.
  - A glitch shorter than DB_CYCLES never produces a pulse.
  - choice is 2-flop synchronized only (no debounce).
- FSM transitions, evaluated each clock. Priority within a state follows the listed order.
  - IDLE:
    - began press → READY; level ← synced choice; clear=1 that cycle.
    - All other inputs ignored.
  - READY:
    - quit press → IDLE.
    - pushin press → PLAY; flap=1 that cycle.
  - PLAY:
    - quit press → IDLE.
    - collision=1 → OVER; hold counter ← 0.
    - paus press → PAUSE.
    - pushin press → flap=1, state stays PLAY.
  - PAUSE:
    - quit press → IDLE.
    - paus press → PLAY.
    - pushin and collision ignored; no flap.
  - OVER:
    - quit press → IDLE, accepted at any time.
    - Hold counter increments on each frame_tick and saturates at OVER_FRAMES.
    - While count < OVER_FRAMES, began is ignored.
    - Once count = OVER_FRAMES, began press → READY; level relatched; clear=1.
- step = frame_tick AND state==PLAY, registered with 1-cycle latency. No step on the cycle of the PLAY→OVER transition, or later.
- play_frames:
  - Cleared together with clear.
  - Increments on each step.
  - Saturates at 2^CNT_W-1.
  - Holds its value in PAUSE, OVER and IDLE so the final score stays readable.
- flap and clear are registered, exactly 1 cycle wide, and never asserted outside the transitions listed above.
- Simultaneous presses in the same cycle resolve strictly by the priority order above. Example: quit plus paus in PLAY → IDLE.
- Reset asserted mid-game returns every output to its reset value immediately. Play resumes only through the normal IDLE→READY→PLAY path.
- Illegal state encodings 5–7 → IDLE on the next clock.

Optional Feature:
- Macro: AUTO_RESTART_EN.
- Defined: in OVER, when the hold counter reaches OVER_FRAMES, the FSM goes to READY automatically on the next clock, with clear=1 and level relatched. began is not required. quit still has priority on that same cycle.
- Undefined: OVER waits indefinitely for a began or quit press, as specified in Behaviour.

Test Plan (DB_CYCLES=4, OVER_FRAMES=3):
- Reset then began held high 10 clocks with choice=3'd5 → began press 6 clocks after the raw edge; state 0→1; clear=1 for exactly 1 cycle; level=5; play_frames=0.
- In READY, pushin pulsed high for 2 clocks → no flap, state stays 1. Then pushin held for 8 clocks → state=2, flap=1 for 1 cycle.
- In PLAY, 5 frame_ticks → 5 step pulses and play_frames=5. Then paus press → state=3; 3 more frame_ticks → no step, play_frames still 5. Then paus press → state=2.
- In PLAY, collision=1 → state=4 next clock, no further step.
  - began press after 1 frame_tick → ignored.
  - After 3 frame_ticks, began press → state=1, clear=1, play_frames=0.
  - With AUTO_RESTART_EN defined → state=1 on the clock after the 3rd tick, with no press.
- In PLAY, quit and paus pressed in the same cycle, with collision=1 → state=0; rst asserted mid-PLAY → state=0, level=0 and play_frames=0 asynchronously, before the next clock edge.
